// File: rtl/kmap_pkg.sv
// Shared types and sizes for the K-map sweep sequencer.
// No logic; consumed by the controller and its settle timer.
// No flow control of its own.
package kmap_pkg;
  localparam int CODE_W    = 3;
  localparam int OUT_W     = 4;
  localparam int NUM_CODES = 8;
  localparam int SETTLE_W  = 4;

  localparam logic [CODE_W-1:0] LAST_CODE = CODE_W'(NUM_CODES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_e;
endpackage

// File: rtl/kmap_settle_timer.sv
// Settle timer: counts cycles a code has been held, flags the last settle cycle.
// expired_o is combinational from the count (0 cycles added).
// No backpressure; clr_i wins over en_i.
module kmap_settle_timer
  import kmap_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [SETTLE_W-1:0] LAST_CNT = SETTLE_W'(SETTLE - 1);

  logic [SETTLE_W-1:0] cnt_q, cnt_d;

  // Next count: clear outside the settle window, otherwise advance while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + SETTLE_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/kmap_sweep_ctrl.sv
// Sweeps all 3-bit codes into a K-map block, samples after SETTLE cycles, compares to golden.
// Each code takes SETTLE+1 cycles; done pulses 8*(SETTLE+1) cycles after the start edge.
// start only honoured in IDLE; abort returns to IDLE keeping partial results.
module kmap_sweep_ctrl
  import kmap_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [CODE_W-1:0] dut_in,
  input  logic [OUT_W-1:0]  dut_out,
  input  logic [OUT_W-1:0]  exp_out,
  output logic              busy,
  output logic              done,
  output logic              result_valid,
  output logic [7:0]        fail_mask,
  output logic [3:0]        err_count,
  output logic [CODE_W-1:0] first_fail,
  output logic              first_fail_vld
);

  state_e            state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [7:0]        fail_mask_q, fail_mask_d;
  logic [3:0]        err_count_q, err_count_d;
  logic [CODE_W-1:0] first_fail_q, first_fail_d;
  logic              first_fail_vld_q, first_fail_vld_d;
  logic              result_valid_q, result_valid_d;
  logic              expired;
  logic              launch;
  logic              mismatch;

  // A sweep launches only from IDLE, and abort vetoes it.
  assign launch   = (state_q == ST_IDLE) && start && !abort;
  assign mismatch = (dut_out != exp_out);

  kmap_settle_timer #(
    .SETTLE (SETTLE)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (state_q != ST_SETTLE),
    .en_i      (state_q == ST_SETTLE),
    .expired_o (expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: settle, sample once, step to the next code or finish; abort bails out.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (launch) state_d = ST_SETTLE;
      ST_SETTLE: begin
        if (abort)        state_d = ST_IDLE;
        else if (expired) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (abort)                  state_d = ST_IDLE;
        else if (code_q == LAST_CODE) state_d = ST_DONE;
        else                        state_d = ST_SETTLE;
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; IDLE parks the K-map input at code 0.
  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    dut_in = code_q;
    unique case (state_q)
      ST_IDLE:   dut_in = '0;
      ST_SETTLE: busy   = 1'b1;
      ST_SAMPLE: busy   = 1'b1;
      ST_DONE:   done   = 1'b1;
      default:   dut_in = '0;
    endcase
  end

  // Datapath next values: clear on launch, record on the sample cycle (even when aborting).
  always_comb begin
    code_d           = code_q;
    fail_mask_d      = fail_mask_q;
    err_count_d      = err_count_q;
    first_fail_d     = first_fail_q;
    first_fail_vld_d = first_fail_vld_q;
    result_valid_d   = result_valid_q;
    if (launch) begin
      code_d           = '0;
      fail_mask_d      = '0;
      err_count_d      = '0;
      first_fail_d     = '0;
      first_fail_vld_d = 1'b0;
      result_valid_d   = 1'b0;
    end
    if (state_q == ST_SAMPLE) begin
      if (mismatch) begin
        fail_mask_d[code_q] = 1'b1;
        err_count_d         = err_count_q + 4'd1;
        if (!first_fail_vld_q) begin
          first_fail_d     = code_q;
          first_fail_vld_d = 1'b1;
        end
      end
      if (!abort && (code_q != LAST_CODE)) begin
        code_d = code_q + CODE_W'(1);
      end
    end
    if (state_q == ST_DONE) begin
      result_valid_d = 1'b1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      code_q           <= '0;
      fail_mask_q      <= '0;
      err_count_q      <= '0;
      first_fail_q     <= '0;
      first_fail_vld_q <= 1'b0;
      result_valid_q   <= 1'b0;
    end else begin
      code_q           <= code_d;
      fail_mask_q      <= fail_mask_d;
      err_count_q      <= err_count_d;
      first_fail_q     <= first_fail_d;
      first_fail_vld_q <= first_fail_vld_d;
      result_valid_q   <= result_valid_d;
    end
  end

  assign fail_mask      = fail_mask_q;
  assign err_count      = err_count_q;
  assign first_fail     = first_fail_q;
  assign first_fail_vld = first_fail_vld_q;
  assign result_valid   = result_valid_q;

endmodule

// File: tb/tb_kmap_sweep_ctrl.sv
// Bench for kmap_sweep_ctrl with two instances (SETTLE=1 and SETTLE=3).
// A table-driven K-map model supplies dut_out; exp_out differs on chosen codes.
// Expected results are derived from the chosen fail pattern and sweep timing.
module tb_kmap_sweep_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic       sel;
  logic       start, abort;
  logic [3:0] golden [8];
  logic [3:0] flip   [8];

  logic       start1, abort1, start3, abort3;
  logic [2:0] dut_in1, dut_in3, ff1, ff3;
  logic [3:0] dut_out1, exp_out1, dut_out3, exp_out3, ec1, ec3;
  logic [7:0] fm1, fm3;
  logic       busy1, done1, rv1, ffv1, busy3, done3, rv3, ffv3;

  assign start1 = start & ~sel;
  assign abort1 = abort & ~sel;
  assign start3 = start & sel;
  assign abort3 = abort & sel;

  assign dut_out1 = golden[dut_in1];
  assign exp_out1 = golden[dut_in1] ^ flip[dut_in1];
  assign dut_out3 = golden[dut_in3];
  assign exp_out3 = golden[dut_in3] ^ flip[dut_in3];

  kmap_sweep_ctrl #(.SETTLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1),
    .dut_in(dut_in1), .dut_out(dut_out1), .exp_out(exp_out1),
    .busy(busy1), .done(done1), .result_valid(rv1), .fail_mask(fm1),
    .err_count(ec1), .first_fail(ff1), .first_fail_vld(ffv1)
  );

  kmap_sweep_ctrl #(.SETTLE(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .abort(abort3),
    .dut_in(dut_in3), .dut_out(dut_out3), .exp_out(exp_out3),
    .busy(busy3), .done(done3), .result_valid(rv3), .fail_mask(fm3),
    .err_count(ec3), .first_fail(ff3), .first_fail_vld(ffv3)
  );

  logic [2:0] o_dut_in, o_ff;
  logic [3:0] o_ec;
  logic [7:0] o_fm;
  logic       o_busy, o_done, o_rv, o_ffv;
  assign o_dut_in = sel ? dut_in3 : dut_in1;
  assign o_ff     = sel ? ff3 : ff1;
  assign o_ec     = sel ? ec3 : ec1;
  assign o_fm     = sel ? fm3 : fm1;
  assign o_busy   = sel ? busy3 : busy1;
  assign o_done   = sel ? done3 : done1;
  assign o_rv     = sel ? rv3 : rv1;
  assign o_ffv    = sel ? ffv3 : ffv1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Random K-map contents; codes flagged in fm get a nonzero output difference.
  task automatic set_tables(input logic [7:0] fm, input bit inv);
    for (int k = 0; k < 8; k++) begin
      golden[k] = 4'($urandom);
      if (fm[k]) flip[k] = inv ? 4'hF : 4'($urandom_range(1, 15));
      else       flip[k] = 4'h0;
    end
  endtask

  function automatic int lowest(input logic [7:0] m);
    int r = 0;
    for (int k = 7; k >= 0; k--) if (m[k]) r = k;
    return r;
  endfunction

  task automatic chk_results(input logic [7:0] fm);
    chk("fail_mask", 32'(o_fm), 32'(fm));
    chk("err_count", 32'(o_ec), 32'($countones(fm)));
    chk("first_fail_vld", 32'(o_ffv), 32'(fm != 8'h00));
    if (fm != 8'h00) chk("first_fail", 32'(o_ff), 32'(lowest(fm)));
  endtask

  task automatic chk_reset();
    chk("rst_dut_in", 32'(o_dut_in), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_rv", 32'(o_rv), 32'd0);
    chk("rst_fail_mask", 32'(o_fm), 32'd0);
    chk("rst_err_count", 32'(o_ec), 32'd0);
    chk("rst_first_fail", 32'(o_ff), 32'd0);
    chk("rst_ffv", 32'(o_ffv), 32'd0);
  endtask

  // Full sweep: every busy cycle, the done cycle and the final results.
  task automatic run_sweep(input int s, input logic [7:0] fm, input bit inv);
    set_tables(fm, inv);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 8 * (s + 1); i++) begin
      chk("sweep_busy", 32'(o_busy), 32'd1);
      chk("sweep_dut_in", 32'(o_dut_in), 32'((i - 1) / (s + 1)));
      chk("sweep_no_early_done", 32'(o_done), 32'd0);
      tick();
    end
    chk("sweep_done", 32'(o_done), 32'd1);
    chk("sweep_done_busy", 32'(o_busy), 32'd0);
    chk("sweep_done_dut_in", 32'(o_dut_in), 32'd7);
    tick();
    chk("sweep_after_done", 32'(o_done), 32'd0);
    chk("sweep_rv", 32'(o_rv), 32'd1);
    chk("sweep_idle_dut_in", 32'(o_dut_in), 32'd0);
    chk_results(fm);
  endtask

  initial begin
    logic [7:0] fm;
    int         off;

    rst = 1'b1; start = 1'b0; abort = 1'b0; sel = 1'b0;
    set_tables(8'h00, 1'b0);
    tick();
    tick();
    chk_reset();
    sel = 1'b1;
    #1;
    chk_reset();
    sel = 1'b0;
    rst = 1'b0;
    tick();

    // SETTLE=1 sweeps: all match, codes 2 and 5, all inverted, random patterns.
    run_sweep(1, 8'h00, 1'b0);
    run_sweep(1, 8'h24, 1'b0);
    run_sweep(1, 8'hFF, 1'b1);
    for (int n = 0; n < 3; n++) run_sweep(1, 8'($urandom), 1'b0);

    // start held high: back-to-back sweeps with one IDLE cycle, then start+abort in IDLE.
    fm = 8'($urandom);
    set_tables(fm, 1'b0);
    start = 1'b1;
    tick();
    for (int sw = 0; sw < 2; sw++) begin
      for (int i = 1; i <= 16; i++) begin
        chk("held_busy", 32'(o_busy), 32'd1);
        chk("held_rv_cleared", 32'(o_rv), 32'd0);
        tick();
      end
      chk("held_done", 32'(o_done), 32'd1);
      tick();
      chk("held_gap_busy", 32'(o_busy), 32'd0);
      chk("held_gap_rv", 32'(o_rv), 32'd1);
      chk_results(fm);
      if (sw == 1) abort = 1'b1;
      tick();
    end
    chk("start_abort_busy", 32'(o_busy), 32'd0);
    chk("start_abort_rv", 32'(o_rv), 32'd1);
    chk_results(fm);
    start = 1'b0;
    abort = 1'b0;
    tick();

    // SETTLE=3: abort while dut_in=4 is settling.
    sel = 1'b1;
    #1;
    fm = 8'($urandom) | 8'h01;
    set_tables(fm, 1'b0);
    off = $urandom_range(0, 2);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 16 + off; i++) tick();
    chk("abort_pre_dut_in", 32'(o_dut_in), 32'd4);
    chk("abort_pre_busy", 32'(o_busy), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 32'(o_busy), 32'd0);
    chk("abort_done", 32'(o_done), 32'd0);
    chk("abort_rv", 32'(o_rv), 32'd0);
    chk("abort_dut_in", 32'(o_dut_in), 32'd0);
    chk_results(fm & 8'h0F);
    for (int i = 0; i < 5; i++) begin
      chk("abort_no_done", 32'(o_done), 32'd0);
      tick();
    end

    // A new start clears retained results; abort in SAMPLE of code 1 still records it.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_fm_clear", 32'(o_fm), 32'd0);
    chk("restart_ec_clear", 32'(o_ec), 32'd0);
    chk("restart_ffv_clear", 32'(o_ffv), 32'd0);
    for (int i = 0; i < 7; i++) tick();
    chk("sample_abort_dut_in", 32'(o_dut_in), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("sample_abort_busy", 32'(o_busy), 32'd0);
    chk("sample_abort_rv", 32'(o_rv), 32'd0);
    chk_results(fm & 8'h03);
    tick();
    run_sweep(3, 8'($urandom), 1'b0);

    // Reset mid-sweep at code 6, with start held through the reset edge.
    sel = 1'b0;
    #1;
    set_tables(8'($urandom), 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("pre_rst_dut_in", 32'(o_dut_in), 32'd6);
    rst = 1'b1;
    start = 1'b1;
    tick();
    chk_reset();
    rst = 1'b0;
    start = 1'b0;
    tick();
    chk("post_rst_idle", 32'(o_busy), 32'd0);
    run_sweep(1, 8'($urandom), 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
